pwm_duty_ctrl: RTL and testbench

PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

---
 rtl/pwm_pkg.sv | 32 +++
 rtl/pwm_duty_ctrl_if.sv | 34 +++
 rtl/btn_debounce.sv | 67 ++++++
 rtl/pwm_duty_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pwm_duty_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty controller: the hold-FSM state encoding, parameter defaults
// and the saturating duty-step helper.
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_INC_HELD = 2'd1,
      ST_DEC_HELD = 2'd2,
      ST_BOTH     = 2'd3
   } hold_st_e;

   localparam int DEF_PERIOD    = 50;
   localparam int DEF_STEP      = 5;
   localparam int DEF_INIT_DUTY = 15;

   // Sum is formed 9 bits wide so a large step near 255 cannot wrap before the clamp.
   function automatic logic [7:0] step_duty(input logic [7:0] cur,
                                            input logic [7:0] step,
                                            input logic [7:0] limit,
                                            input logic       up);
      logic [8:0] sum;
      logic [7:0] res;
      sum = {1'b0, cur} + {1'b0, step};
      if (up) begin
         res = (sum > {1'b0, limit}) ? limit : sum[7:0];
      end else begin
         res = (cur < step) ? 8'd0 : (cur - step);
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Button inputs and PWM status outputs of the duty controller, bundled for the top-level port.
// The DUT takes the slave view; the driver/observer takes the master view.
interface pwm_duty_ctrl_if;
   logic       inc;
   logic       dec;
   logic       pwm_out;
   logic [7:0] duty;
   logic [7:0] count;
   logic       period_start;
   logic       at_max;
   logic       at_min;

   modport slave (
      input  inc,
      input  dec,
      output pwm_out,
      output duty,
      output count,
      output period_start,
      output at_max,
      output at_min
   );

   modport master (
      output inc,
      output dec,
      input  pwm_out,
      input  duty,
      input  count,
      input  period_start,
      input  at_max,
      input  at_min
   );
endinterface

// File: rtl/btn_debounce.sv
// Raw active-low button -> 2-flop synchronizer -> level debouncer -> one-cycle press pulse.
// The press pulse is high in the first cycle the debounced level reads low; no backpressure.
module btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clkin,
   input  logic reset,
   input  logic btn_n_i,
   output logic level_o,
   output logic press_o
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          level_q;
   logic          level_d;
   logic          level_prev_q;
   logic [1:0]    flush_q;
   logic          armed_q;
   logic          armed_d;

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         cnt_q        <= '0;
         level_q      <= 1'b1;
         level_prev_q <= 1'b1;
         flush_q      <= 2'b00;
         armed_q      <= 1'b0;
      end else begin
         sync1_q      <= btn_n_i;
         sync2_q      <= sync1_q;
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         level_prev_q <= level_q;
         flush_q      <= {flush_q[0], 1'b1};
         armed_q      <= armed_d;
      end
   end

   // cnt_q counts consecutive synchronized samples that disagree with the accepted level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // A button held through reset must be seen released (with the synchronizer flushed) before
   // its next falling edge counts as a press.
   assign armed_d = armed_q | (flush_q[1] & sync2_q & level_q);

   assign press_o = armed_q & level_prev_q & ~level_q;
   assign level_o = level_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Button-driven PWM: debounced inc/dec step a saturating target duty, with hold-to-repeat.
// Applied duty changes only at a period boundary; pwm_out is registered and aligned with count.
module pwm_duty_ctrl
   import pwm_pkg::*;
#(
   parameter int PERIOD      = DEF_PERIOD,
   parameter int STEP        = DEF_STEP,
   parameter int INIT_DUTY   = DEF_INIT_DUTY,
   parameter int DEB_CYCLES  = 16,
   parameter int HOLD_CYCLES = 1024,
   parameter int RPT_CYCLES  = 256
) (
   input  logic           clkin,
   input  logic           reset,
   pwm_duty_ctrl_if.slave bus
);

   localparam logic [7:0] PER_LAST = 8'(PERIOD - 1);
   localparam logic [7:0] PER_MAX  = 8'(PERIOD);
   localparam logic [7:0] STEP_V   = 8'(STEP);
   localparam logic [7:0] INIT_V   = 8'(INIT_DUTY);
   localparam int RC_MAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
   localparam int RCW    = $clog2(RC_MAX + 1);
   localparam logic [RCW-1:0] HOLD_V = RCW'(HOLD_CYCLES);
   localparam logic [RCW-1:0] RPT_V  = RCW'(RPT_CYCLES);

   logic           inc_lvl;
   logic           inc_press;
   logic           dec_lvl;
   logic           dec_press;

   hold_st_e       state_q;
   hold_st_e       state_d;
   logic [RCW-1:0] rpt_cnt_q;
   logic [RCW-1:0] rpt_cnt_d;
   logic           rpt_ph_q;
   logic           rpt_ph_d;
   logic           ev_up;
   logic           ev_dn;

   logic [7:0]     count_q;
   logic [7:0]     count_d;
   logic [7:0]     tgt_q;
   logic [7:0]     tgt_d;
   logic [7:0]     duty_q;
   logic [7:0]     duty_d;
   logic           pwm_q;
   logic           pwm_d;

   logic           held_inc;
   logic           other_press;
   logic           held_rel;
   logic [RCW-1:0] rpt_lim;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc_deb (
      .clkin   (clkin),
      .reset   (reset),
      .btn_n_i (bus.inc),
      .level_o (inc_lvl),
      .press_o (inc_press)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec_deb (
      .clkin   (clkin),
      .reset   (reset),
      .btn_n_i (bus.dec),
      .level_o (dec_lvl),
      .press_o (dec_press)
   );

   assign held_inc    = (state_q == ST_INC_HELD);
   assign other_press = held_inc ? dec_press : inc_press;
   assign held_rel    = held_inc ? inc_lvl : dec_lvl;
   assign rpt_lim     = rpt_ph_q ? RPT_V : HOLD_V;

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rpt_cnt_q <= '0;
         rpt_ph_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rpt_cnt_q <= rpt_cnt_d;
         rpt_ph_q  <= rpt_ph_d;
      end
   end

   // rpt_cnt_q holds the number of cycles since the press (or since the last repeat) while held.
   always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      rpt_ph_d  = rpt_ph_q;
      ev_up     = 1'b0;
      ev_dn     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rpt_cnt_d = RCW'(1);
            rpt_ph_d  = 1'b0;
            if (inc_press && dec_press) begin
               state_d = ST_BOTH;
            end else if (inc_press) begin
               state_d = ST_INC_HELD;
               ev_up   = 1'b1;
            end else if (dec_press) begin
               state_d = ST_DEC_HELD;
               ev_dn   = 1'b1;
            end
         end
         ST_INC_HELD, ST_DEC_HELD: begin
            if (other_press) begin
               state_d = ST_BOTH;
            end else if (held_rel) begin
               state_d = ST_IDLE;
            end else if (rpt_cnt_q == rpt_lim) begin
               rpt_cnt_d = RCW'(1);
               rpt_ph_d  = 1'b1;
               ev_up     = held_inc;
               ev_dn     = ~held_inc;
            end else begin
               rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
         end
         ST_BOTH: begin
            if (inc_lvl && dec_lvl) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      tgt_d = tgt_q;
      if (ev_up) begin
         tgt_d = step_duty(tgt_q, STEP_V, PER_MAX, 1'b1);
      end else if (ev_dn) begin
         tgt_d = step_duty(tgt_q, STEP_V, PER_MAX, 1'b0);
      end
      count_d = (count_q == PER_LAST) ? 8'd0 : (count_q + 8'd1);
      duty_d  = (count_q == PER_LAST) ? tgt_q : duty_q;
      pwm_d   = (count_d < duty_d);
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         count_q <= 8'd0;
         tgt_q   <= INIT_V;
         duty_q  <= INIT_V;
         pwm_q   <= (INIT_V != 8'd0);
      end else begin
         count_q <= count_d;
         tgt_q   <= tgt_d;
         duty_q  <= duty_d;
         pwm_q   <= pwm_d;
      end
   end

   assign bus.pwm_out      = pwm_q;
   assign bus.duty         = duty_q;
   assign bus.count        = count_q;
   assign bus.period_start = (count_q == 8'd0);
   assign bus.at_max       = (tgt_q == PER_MAX);
   assign bus.at_min       = (tgt_q == 8'd0);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl: stimulus queues per-period expectations, a monitor checks
// duty/flags at each period start and pwm high-time over the whole period.
module tb_pwm_duty_ctrl;
   import pwm_pkg::*;

   localparam int PER = 50;

   typedef struct {
      int duty;
      int mx;
      int mn;
   } exp_t;

   logic clkin;
   logic reset;
   int   n_cmp;
   int   n_bad;
   exp_t exp_q[$];

   pwm_duty_ctrl_if bus_if();

   pwm_duty_ctrl #(
      .PERIOD      (PER),
      .STEP        (5),
      .INIT_DUTY   (15),
      .DEB_CYCLES  (4),
      .HOLD_CYCLES (20),
      .RPT_CYCLES  (10)
   ) dut (
      .clkin (clkin),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic wait_count(input int v);
      int n;
      n = 0;
      do begin
         @(negedge clkin);
         n++;
      end while (int'(bus_if.count) != v && n < 400);
      if (int'(bus_if.count) != v) chk("wait_count_timeout", int'(bus_if.count), v);
   endtask

   // Queue an expectation for the next full period, then step into that period so that
   // later stimulus can only move the target, never the latched duty.
   task automatic exp_next(input int d, input int mx, input int mn);
      exp_t e;
      wait_count(30);
      e.duty = d;
      e.mx   = mx;
      e.mn   = mn;
      exp_q.push_back(e);
      wait_count(2);
   endtask

   task automatic press(input bit use_inc, input bit use_dec, input int low_cyc, input int high_cyc);
      if (use_inc) bus_if.inc = 1'b0;
      if (use_dec) bus_if.dec = 1'b0;
      repeat (low_cyc) @(negedge clkin);
      bus_if.inc = 1'b1;
      bus_if.dec = 1'b1;
      repeat (high_cyc) @(negedge clkin);
   endtask

   initial begin : monitor
      exp_t cur;
      int   hi;
      int   prev;
      bit   act;
      bit   pv;
      act  = 1'b0;
      pv   = 1'b0;
      hi   = 0;
      prev = 0;
      forever begin
         @(negedge clkin);
         if (reset) begin
            act = 1'b0;
            pv  = 1'b0;
         end else begin
            if (pv) chk("count_seq", int'(bus_if.count), (prev == PER - 1) ? 0 : prev + 1);
            prev = int'(bus_if.count);
            pv   = 1'b1;
            chk("period_start", int'(bus_if.period_start), int'(bus_if.count == 8'd0));
            if (bus_if.period_start) begin
               if (act) chk("pwm_high_cycles", hi, cur.duty);
               act = 1'b0;
               if (exp_q.size() > 0) begin
                  cur = exp_q.pop_front();
                  act = 1'b1;
                  hi  = 0;
                  chk("duty", int'(bus_if.duty), cur.duty);
                  chk("at_max", int'(bus_if.at_max), cur.mx);
                  chk("at_min", int'(bus_if.at_min), cur.mn);
               end
            end
            if (act) hi += int'(bus_if.pwm_out);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      n_cmp      = 0;
      n_bad      = 0;
      reset      = 1'b1;
      bus_if.inc = 1'b1;
      bus_if.dec = 1'b1;
      repeat (3) @(negedge clkin);
      chk("rst_count", int'(bus_if.count), 0);
      chk("rst_duty", int'(bus_if.duty), 15);
      chk("rst_pwm", int'(bus_if.pwm_out), 1);
      chk("rst_period_start", int'(bus_if.period_start), 1);
      chk("rst_at_max", int'(bus_if.at_max), 0);
      chk("rst_at_min", int'(bus_if.at_min), 0);
      @(posedge clkin);
      #2 reset = 1'b0;

      // Idle periods at the reset duty.
      exp_next(15, 0, 0);
      exp_next(15, 0, 0);

      // Press at count 20: the running period keeps 15, the next one gets 20.
      wait_count(20);
      press(1'b1, 1'b0, 8, 0);
      exp_next(20, 0, 0);

      // 3-cycle glitch is rejected, 4-cycle press is accepted.
      wait_count(5);
      press(1'b1, 1'b0, 3, 12);
      exp_next(20, 0, 0);
      wait_count(5);
      press(1'b1, 1'b0, 4, 12);
      exp_next(25, 0, 0);

      // Saturate up, then down.
      for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 6, 8);
      exp_next(50, 1, 0);
      for (int i = 0; i < 11; i++) press(1'b0, 1'b1, 6, 8);
      exp_next(0, 0, 1);
      for (int i = 0; i < 6; i++) press(1'b1, 1'b0, 6, 8);
      exp_next(30, 0, 0);

      // Held dec: press plus repeats at +20,+30,+40,+50 -> 5, released before +60.
      press(1'b0, 1'b1, 58, 20);
      exp_next(5, 0, 0);
      exp_next(5, 0, 0);

      // Both buttons pressed together.
      bus_if.inc = 1'b0;
      bus_if.dec = 1'b0;
      repeat (8) @(negedge clkin);
      chk("fsm_both", int'(dut.state_q), int'(ST_BOTH));
      repeat (6) @(negedge clkin);
      bus_if.inc = 1'b1;
      bus_if.dec = 1'b1;
      repeat (15) @(negedge clkin);
      exp_next(5, 0, 0);

      // Reset pulse during an inc hold; inc stays low across reset release.
      wait_count(1);
      bus_if.inc = 1'b0;
      repeat (12) @(negedge clkin);
      @(posedge clkin);
      #2 reset = 1'b1;
      repeat (3) @(negedge clkin);
      chk("midrst_duty", int'(bus_if.duty), 15);
      chk("midrst_count", int'(bus_if.count), 0);
      chk("midrst_pwm", int'(bus_if.pwm_out), 1);
      @(posedge clkin);
      #2 reset = 1'b0;
      repeat (30) @(negedge clkin);
      bus_if.inc = 1'b1;
      repeat (20) @(negedge clkin);
      exp_next(15, 0, 0);
      exp_next(15, 0, 0);

      // Buttons still work after the held-through-reset release.
      press(1'b1, 1'b0, 6, 8);
      exp_next(20, 0, 0);

      wait_count(3);
      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
